// File: rtl/sprite_pkg.sv
// Shared types and helpers for the animated sprite renderer.
package sprite_pkg;

    typedef logic [11:0] pixel_t;

    // Cycles from (hcount, vcount) presentation to the matching pixel output.
    localparam int unsigned PIPE_LAT = 5;

    function automatic int unsigned sprite_addr_w(input int unsigned frames,
                                                  input int unsigned w,
                                                  input int unsigned h);
        return $clog2(frames * w * h);
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Stage 0 of the sprite pipeline: per-video-frame position latch, footprint
// compare and image BROM address generation.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int unsigned WIDTH      = 100,
    parameter int unsigned HEIGHT     = 100,
    parameter int unsigned FRAMES     = 4,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned FW         = 2,
    parameter int unsigned AW         = sprite_addr_w(FRAMES, WIDTH, HEIGHT)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          new_frame_i,
    input  logic [10:0]   x_i,
    input  logic [9:0]    y_i,
    input  logic [10:0]   hcount_i,
    input  logic [9:0]    vcount_i,
    input  logic [FW-1:0] frame_idx_i,
    output logic [AW-1:0] addr_o,
    output logic          hit_o
);

    // One extra bit on each axis so the far edge never wraps.
    localparam logic [11:0]   DW       = 12'(WIDTH << SCALE_LOG2);
    localparam logic [10:0]   DH       = 11'(HEIGHT << SCALE_LOG2);
    localparam int unsigned   FRAME_SZ = WIDTH * HEIGHT;

    logic [10:0]   lx_q, lx_d;
    logic [9:0]    ly_q, ly_d;
    logic [10:0]   col;
    logic [9:0]    row;
    logic          hit_d, hit_q;
    logic [AW-1:0] addr_d, addr_q;

    // Position is sampled only at the frame pulse (and during reset).
    always_comb begin
        lx_d = lx_q;
        ly_d = ly_q;
        if (rst_i || new_frame_i) begin
            lx_d = x_i;
            ly_d = y_i;
        end
    end

    // Footprint compare and linear address into the frame-stacked image.
    always_comb begin
        hit_d = ({1'b0, hcount_i} >= {1'b0, lx_q}) &&
                ({1'b0, hcount_i} <  ({1'b0, lx_q} + DW)) &&
                ({1'b0, vcount_i} >= {1'b0, ly_q}) &&
                ({1'b0, vcount_i} <  ({1'b0, ly_q} + DH));
        col    = (hcount_i - lx_q) >> SCALE_LOG2;
        row    = (vcount_i - ly_q) >> SCALE_LOG2;
        addr_d = AW'(32'(frame_idx_i) * FRAME_SZ + 32'(row) * WIDTH + 32'(col));
    end

    // Latch and stage-0 registers.
    always_ff @(posedge clk_i) begin
        lx_q <= lx_d;
        ly_q <= ly_d;
        if (rst_i) begin
            hit_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            hit_q  <= hit_d;
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign hit_o  = hit_q;

endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM (vendor template shape). Contents come
// from INIT_FILE through the implementation flow's memory initialisation.
module xilinx_single_port_ram_read_first #(
    parameter int unsigned RAM_WIDTH       = 18,
    parameter int unsigned RAM_DEPTH       = 1024,
    parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter string       INIT_FILE       = ""
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         ena,
    input  logic                         rsta,
    input  logic                         regcea,
    output logic [RAM_WIDTH-1:0]         douta
);

    // An instance bound to an init file is a ROM: port-A writes are ignored.
    localparam bit WRITABLE = (INIT_FILE == "");

    logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_q;

    // Read-first array access.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea && WRITABLE) begin
                bram[addra] <= dina;
            end
            ram_data_q <= bram[addra];
        end
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
        assign douta = ram_data_q;
    end else begin : g_high_perf
        logic [RAM_WIDTH-1:0] douta_q;
        // Optional output register adding one cycle of latency.
        always_ff @(posedge clka) begin
            if (rsta) begin
                douta_q <= '0;
            end else if (regcea) begin
                douta_q <= ram_data_q;
            end
        end
        assign douta = douta_q;
    end

endmodule

// File: rtl/animated_sprite_gen.sv
// Multi-frame sprite renderer: image BROM -> palette BROM, 5-cycle latency,
// power-of-two scaling and frame-hold animation.
// Optional feature macro: SPRITE_TRANSPARENCY_EN (palette index 0 not drawn).
module animated_sprite_gen
    import sprite_pkg::*;
#(
    parameter int unsigned WIDTH         = 100,
    parameter int unsigned HEIGHT        = 100,
    parameter int unsigned FRAMES        = 4,
    parameter int unsigned SCALE_LOG2    = 0,
    parameter int unsigned FRAME_HOLD    = 8,
    parameter int unsigned PALETTE_DEPTH = 256,
    parameter string       IMAGE_FILE    = "sprite_image.mem",
    parameter string       PALETTE_FILE  = "sprite_palette.mem"
) (
    input  logic                                  pixel_clk_in,
    input  logic                                  rst_in,
    input  logic [10:0]                           x_in,
    input  logic [9:0]                            y_in,
    input  logic [10:0]                           hcount_in,
    input  logic [9:0]                            vcount_in,
    input  logic                                  new_frame_in,
    input  logic                                  anim_en_in,
    output logic [(FRAMES > 1 ? $clog2(FRAMES) : 1)-1:0] frame_idx_out,
    output logic [11:0]                           pixel_out,
    output logic                                  pixel_valid_out
);

    localparam int unsigned FW  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int unsigned HW  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int unsigned AW  = sprite_addr_w(FRAMES, WIDTH, HEIGHT);
    localparam int unsigned PAW = $clog2(PALETTE_DEPTH);

    logic [FW-1:0]         frame_q, frame_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [AW-1:0]         img_addr;
    logic                  hit_s0;
    logic [7:0]            img_idx;
    pixel_t                pal_rgb;
    logic [PIPE_LAT-2:0]   hit_pipe_q;
    logic                  draw;

    // Frame-hold counter and animation frame advance on the vblank pulse.
    always_comb begin
        hold_d  = hold_q;
        frame_d = frame_q;
        if (new_frame_in && anim_en_in) begin
            if (hold_q == HW'(FRAME_HOLD - 1)) begin
                hold_d  = '0;
                frame_d = (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // Animation state registers.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hold_q  <= '0;
            frame_q <= '0;
        end else begin
            hold_q  <= hold_d;
            frame_q <= frame_d;
        end
    end

    sprite_addr_gen #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .FRAMES     (FRAMES),
        .SCALE_LOG2 (SCALE_LOG2),
        .FW         (FW),
        .AW         (AW)
    ) u_addr_gen (
        .clk_i       (pixel_clk_in),
        .rst_i       (rst_in),
        .new_frame_i (new_frame_in),
        .x_i         (x_in),
        .y_i         (y_in),
        .hcount_i    (hcount_in),
        .vcount_i    (vcount_in),
        .frame_idx_i (frame_q),
        .addr_o      (img_addr),
        .hit_o       (hit_s0)
    );

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH       (8),
        .RAM_DEPTH       (FRAMES * WIDTH * HEIGHT),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE"),
        .INIT_FILE       (IMAGE_FILE)
    ) u_image_rom (
        .addra  (img_addr),
        .dina   (8'd0),
        .clka   (pixel_clk_in),
        .wea    (1'b0),
        .ena    (1'b1),
        .rsta   (rst_in),
        .regcea (1'b1),
        .douta  (img_idx)
    );

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH       (12),
        .RAM_DEPTH       (PALETTE_DEPTH),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE"),
        .INIT_FILE       (PALETTE_FILE)
    ) u_palette_rom (
        .addra  (PAW'(img_idx)),
        .dina   (12'd0),
        .clka   (pixel_clk_in),
        .wea    (1'b0),
        .ena    (1'b1),
        .rsta   (rst_in),
        .regcea (1'b1),
        .douta  (pal_rgb)
    );

    // Hit flag delayed to line up with the palette BROM output.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hit_pipe_q <= '0;
        end else begin
            hit_pipe_q <= {hit_pipe_q[PIPE_LAT-3:0], hit_s0};
        end
    end

`ifdef SPRITE_TRANSPARENCY_EN
    logic [1:0][7:0] idx_pipe_q;

    // Palette index travels alongside the palette read to flag transparency.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            idx_pipe_q <= '0;
        end else begin
            idx_pipe_q <= {idx_pipe_q[0], img_idx};
        end
    end

    assign draw = hit_pipe_q[PIPE_LAT-2] && (idx_pipe_q[1] != 8'd0);
`else
    assign draw = hit_pipe_q[PIPE_LAT-2];
`endif

    assign pixel_valid_out = draw;
    assign pixel_out       = draw ? pal_rgb : 12'd0;
    assign frame_idx_out   = frame_q;

endmodule

// File: tb/tb_animated_sprite_gen.sv
module tb_animated_sprite_gen;

    localparam int PL = 5;
`ifdef SPRITE_TRANSPARENCY_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, nf, ae;
    logic [10:0] x, h;
    logic [9:0]  y, v;
    logic [1:0]  frame, frame2;
    logic [11:0] pix, pix2;
    logic        val, val2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    animated_sprite_gen #(
        .WIDTH(100), .HEIGHT(100), .FRAMES(4), .SCALE_LOG2(0),
        .FRAME_HOLD(2), .PALETTE_DEPTH(256)
    ) dut (
        .pixel_clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y),
        .hcount_in(h), .vcount_in(v), .new_frame_in(nf), .anim_en_in(ae),
        .frame_idx_out(frame), .pixel_out(pix), .pixel_valid_out(val)
    );

    animated_sprite_gen #(
        .WIDTH(100), .HEIGHT(100), .FRAMES(4), .SCALE_LOG2(1),
        .FRAME_HOLD(8), .PALETTE_DEPTH(256)
    ) dut2 (
        .pixel_clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y),
        .hcount_in(h), .vcount_in(v), .new_frame_in(nf), .anim_en_in(ae),
        .frame_idx_out(frame2), .pixel_out(pix2), .pixel_valid_out(val2)
    );

    function automatic logic [7:0] img(input int a);
        return (a == 5) ? 8'd0 : 8'((a % 251) + 1);
    endfunction

    function automatic logic [11:0] pal(input int i);
        return 12'((i * 13 + 'h5A3) % 4096);
    endfunction

    function automatic logic [12:0] drawn(input int a);
        if (TRANSP && img(a) == 8'd0) return 13'h0;
        return {1'b1, pal(int'(img(a)))};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse();
        nf = 1'b1;
        @(negedge clk);
        nf = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle(input int hh, input int vv);
        h = 11'(hh);
        v = 10'(vv);
        repeat (PL) @(negedge clk);
    endtask

    typedef struct {
        int         hh;
        int         vv;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int bad;
        logic [1:0] exp_seq[9];

        for (int a = 0; a < 40000; a++) begin
            dut.u_image_rom.bram[a]  = img(a);
            dut2.u_image_rom.bram[a] = img(a);
        end
        for (int i = 0; i < 256; i++) begin
            dut.u_palette_rom.bram[i]  = pal(i);
            dut2.u_palette_rom.bram[i] = pal(i);
        end

        vecs[0] = '{99,  50,  13'h0};
        vecs[1] = '{100, 50,  drawn(0)};
        vecs[2] = '{105, 50,  TRANSP ? 13'h0 : {1'b1, 12'h5A3}};
        vecs[3] = '{199, 50,  drawn(99)};
        vecs[4] = '{200, 50,  13'h0};
        vecs[5] = '{150, 149, drawn(9950)};
        vecs[6] = '{150, 150, 13'h0};
        vecs[7] = '{150, 49,  13'h0};
        vecs[8] = '{137, 77,  drawn(2737)};

        // Reset state
        rst = 1'b1; nf = 1'b0; ae = 1'b0;
        x = 11'd100; y = 10'd50; h = '0; v = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_valid", 32'(val), 32'd0);
        check("reset_pixel", 32'(pix), 32'd0);
        check("reset_frame", 32'(frame), 32'd0);
        check("reset_frame2", 32'(frame2), 32'd0);

        // Latency: single hitting cycle appears exactly 5 cycles later
        pulse();
        h = 11'd100; v = 10'd50;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 4) check("lat_k4", 32'(val), 32'd0);
            if (k == 5) check("lat_k5", 32'({val, pix}), 32'(drawn(0)));
            if (k == 6) check("lat_k6", 32'(val), 32'd0);
            h = 11'd0; v = 10'd0;
        end

        // Table-driven footprint and address vectors
        for (int i = 0; i < 9; i++) begin
            settle(vecs[i].hh, vecs[i].vv);
            check($sformatf("vec%0d", i), 32'({val, pix}), 32'(vecs[i].exp));
        end

        // Scale x2 footprint (dut2)
        settle(100, 50); check("s1_h100", 32'({val2, pix2}), 32'(drawn(0)));
        settle(101, 50); check("s1_h101", 32'({val2, pix2}), 32'(drawn(0)));
        settle(299, 50); check("s1_h299", 32'({val2, pix2}), 32'(drawn(99)));
        settle(300, 50); check("s1_h300", 32'({val2, pix2}), 32'd0);
        settle(100, 249); check("s1_v249", 32'({val2, pix2}), 32'(drawn(9900)));
        settle(100, 250); check("s1_v250", 32'({val2, pix2}), 32'd0);

        // Clipping at the right screen edge: no wrap
        settle(0, 0);
        x = 11'd2000;
        pulse();
        bad = 0;
        for (int i = 0; i < 105; i++) begin
            h = (i < 100) ? 11'(i) : 11'd0;
            v = 10'd50;
            @(negedge clk);
            if (val !== 1'b0) bad++;
        end
        check("clip_nowrap", 32'(bad), 32'd0);
        settle(2047, 50); check("clip_h2047", 32'({val, pix}), 32'(drawn(47)));
        settle(2000, 50); check("clip_h2000", 32'({val, pix}), 32'(drawn(0)));

        // Position latch
        x = 11'd100;
        pulse();
        settle(100, 50); check("pos_before", 32'({val, pix}), 32'(drawn(0)));
        x = 11'd300;
        settle(100, 50); check("pos_hold_old", 32'({val, pix}), 32'(drawn(0)));
        settle(300, 50); check("pos_hold_new", 32'(val), 32'd0);
        pulse();
        settle(300, 50); check("pos_new", 32'({val, pix}), 32'(drawn(0)));
        settle(100, 50); check("pos_old_gone", 32'(val), 32'd0);

        // Animation sequence
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        ae = 1'b1;
        exp_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        for (int p = 0; p < 9; p++) begin
            check($sformatf("anim_p%0d", p), 32'(frame), 32'(exp_seq[p]));
            pulse();
        end
        ae = 1'b0;
        for (int p = 0; p < 3; p++) begin
            pulse();
            check($sformatf("anim_frozen%0d", p), 32'(frame), 32'd0);
        end
        ae = 1'b1;
        x = 11'd100;
        pulse();
        ae = 1'b0;
        check("anim_frame1", 32'(frame), 32'd1);
        settle(100, 50); check("frame1_base", 32'({val, pix}), 32'(drawn(10000)));
        settle(101, 51); check("frame1_off", 32'({val, pix}), 32'(drawn(10101)));

        // Reset while hitting: 5 zero cycles, then frame 0 data
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_frame", 32'(frame), 32'd0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rst_flush%0d", k), 32'({val, pix}), 32'd0);
            @(negedge clk);
        end
        check("rst_resume", 32'({val, pix}), 32'(drawn(101)));

        // Simultaneous reset and frame pulse: reset wins, position loads
        x = 11'd400; ae = 1'b1;
        rst = 1'b1; nf = 1'b1;
        @(negedge clk);
        rst = 1'b0; nf = 1'b0; ae = 1'b0;
        @(negedge clk);
        check("sim_frame", 32'(frame), 32'd0);
        settle(400, 50); check("sim_pos", 32'({val, pix}), 32'(drawn(0)));
        settle(100, 50); check("sim_old", 32'(val), 32'd0);
        ae = 1'b1;
        pulse(); check("sim_hold1", 32'(frame), 32'd0);
        pulse(); check("sim_hold2", 32'(frame), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
